// File: rtl/ncf_pkg.sv
// Shared constants, FSM state type and bus-slicing helpers for the ncluster frame decoder.
// Optional build macro used by this block: NCF_ERRCNT_EN (per-channel saturating error counters).
package ncf_pkg;

  localparam logic [15:0] MARK_DEFAULT = 16'hAAAA;
  localparam int          ID_W_DEFAULT = 11;
  localparam logic [ID_W_DEFAULT-1:0] ID_ALL_ONES = '1;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } ncf_state_e;

  // LSB of channel k inside a flat bus made of w-bit lanes.
  function automatic int chan_lsb(input int k, input int w);
    return k * w;
  endfunction

  function automatic int chan_msb(input int k, input int w);
    return k * w + w - 1;
  endfunction

endpackage

// File: rtl/ncf_chan.sv
// One decoder channel: header detection, turn->cluster conversion, frame FSM and sticky error flags.
// With NCF_ERRCNT_EN defined, also a saturating per-channel error-event counter.
module ncf_chan
  import ncf_pkg::*;
#(
  parameter int          HDR_W    = 38,
  parameter int          NTURN_W  = 15,
  parameter int          SHIFT    = 2,
  parameter logic [15:0] MARK     = MARK_DEFAULT,
  parameter int          ID_LSB   = 26,
  parameter int          ID_W     = ID_W_DEFAULT,
  parameter int          ERRCNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_err_i,
  input  logic                     valid_i,
  input  logic [HDR_W-1:0]         word_i,
  input  logic [NTURN_W-1:0]       nturn_i,
  output logic                     hdr_valid_o,
  output logic [HDR_W-1:0]         header_o,
  output logic [NTURN_W-SHIFT-1:0] ncluster_o,
  output logic                     in_frame_o,
  output logic                     err_align_o,
  output logic                     err_id_o,
`ifdef NCF_ERRCNT_EN
  output logic                     err_trunc_o,
  output logic [ERRCNT_W-1:0]      err_cnt_o
`else
  output logic                     err_trunc_o
`endif
);

  ncf_state_e                 state_q;
  logic [NTURN_W-1:0]         rem_q;
  logic                       hdr_valid_q;
  logic [HDR_W-1:0]           header_q;
  logic [NTURN_W-SHIFT-1:0]   ncluster_q;
  logic                       err_align_q, err_id_q, err_trunc_q;

  logic is_hdr, ev_align, ev_id, ev_trunc;

  assign is_hdr   = valid_i && (word_i[15:0] == MARK);
  assign ev_align = is_hdr && (nturn_i[SHIFT-1:0] != '0);
  assign ev_id    = is_hdr && (word_i[ID_LSB +: ID_W] != {ID_W{1'b1}});
  // In BODY rem is always non-zero, so any header there cuts a frame short.
  assign ev_trunc = is_hdr && (state_q == BODY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      hdr_valid_q <= 1'b0;
      header_q    <= '0;
      ncluster_q  <= '0;
      err_align_q <= 1'b0;
      err_id_q    <= 1'b0;
      err_trunc_q <= 1'b0;
    end else begin
      hdr_valid_q <= is_hdr;
      header_q    <= is_hdr ? word_i : '0;
      ncluster_q  <= is_hdr ? nturn_i[NTURN_W-1:SHIFT] : '0;
      err_align_q <= (err_align_q & ~clr_err_i) | ev_align;
      err_id_q    <= (err_id_q & ~clr_err_i) | ev_id;
      err_trunc_q <= (err_trunc_q & ~clr_err_i) | ev_trunc;
      if (is_hdr) begin
        rem_q   <= nturn_i;
        state_q <= (nturn_i != '0) ? BODY : IDLE;
      end else if (valid_i && state_q == BODY) begin
        rem_q <= rem_q - 1'b1;
        if (rem_q == NTURN_W'(1)) state_q <= IDLE;
      end
    end
  end

`ifdef NCF_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (ev_align || ev_id || ev_trunc) begin
      if (err_cnt_q != {ERRCNT_W{1'b1}}) err_cnt_q <= err_cnt_q + 1'b1;
    end else if (clr_err_i) begin
      err_cnt_q <= '0;
    end
  end
  assign err_cnt_o = err_cnt_q;
`endif

  assign hdr_valid_o = hdr_valid_q;
  assign header_o    = header_q;
  assign ncluster_o  = ncluster_q;
  assign in_frame_o  = (state_q == BODY);
  assign err_align_o = err_align_q;
  assign err_id_o    = err_id_q;
  assign err_trunc_o = err_trunc_q;

endmodule

// File: rtl/ncluster_frame_decoder.sv
// NCH independent header/payload decoders between link deserialisers and the cluster builder.
// Define NCF_ERRCNT_EN to add the err_cnt port with saturating per-channel error counters.
module ncluster_frame_decoder
  import ncf_pkg::*;
#(
  parameter int          NCH      = 4,
  parameter int          HDR_W    = 38,
  parameter int          NTURN_W  = 15,
  parameter int          SHIFT    = 2,
  parameter logic [15:0] MARK     = MARK_DEFAULT,
  parameter int          ID_LSB   = 26,
  parameter int          ID_W     = ID_W_DEFAULT,
  parameter int          ERRCNT_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr_err,
  input  logic [NCH-1:0]                 in_valid,
  input  logic [NCH*HDR_W-1:0]           word_in,
  input  logic [NCH*NTURN_W-1:0]         nturn_in,
  output logic [NCH-1:0]                 hdr_valid,
  output logic [NCH*HDR_W-1:0]           header_out,
  output logic [NCH*(NTURN_W-SHIFT)-1:0] ncluster,
  output logic [NCH-1:0]                 in_frame,
  output logic [NCH-1:0]                 err_align,
  output logic [NCH-1:0]                 err_id,
`ifdef NCF_ERRCNT_EN
  output logic [NCH-1:0]                 err_trunc,
  output logic [NCH*ERRCNT_W-1:0]        err_cnt
`else
  output logic [NCH-1:0]                 err_trunc
`endif
);

  localparam int NCW = NTURN_W - SHIFT;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    ncf_chan #(
      .HDR_W(HDR_W), .NTURN_W(NTURN_W), .SHIFT(SHIFT), .MARK(MARK),
      .ID_LSB(ID_LSB), .ID_W(ID_W), .ERRCNT_W(ERRCNT_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .clr_err_i  (clr_err),
      .valid_i    (in_valid[gi]),
      .word_i     (word_in[chan_msb(gi, HDR_W):chan_lsb(gi, HDR_W)]),
      .nturn_i    (nturn_in[chan_msb(gi, NTURN_W):chan_lsb(gi, NTURN_W)]),
      .hdr_valid_o(hdr_valid[gi]),
      .header_o   (header_out[chan_msb(gi, HDR_W):chan_lsb(gi, HDR_W)]),
      .ncluster_o (ncluster[chan_msb(gi, NCW):chan_lsb(gi, NCW)]),
      .in_frame_o (in_frame[gi]),
      .err_align_o(err_align[gi]),
      .err_id_o   (err_id[gi]),
`ifdef NCF_ERRCNT_EN
      .err_trunc_o(err_trunc[gi]),
      .err_cnt_o  (err_cnt[chan_msb(gi, ERRCNT_W):chan_lsb(gi, ERRCNT_W)])
`else
      .err_trunc_o(err_trunc[gi])
`endif
    );
  end

endmodule
